// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: mnemonic codes, op/func constants and state types shared by the encoder and the controller decode
package instr_encoder_pkg;
  typedef enum logic [4:0] {
    M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_CL1,
    M_CLZ, M_MUL, M_ROT, M_ADDI, M_ORI, M_LW, M_SW, M_BNE
  } mnem_e;
  typedef enum logic [2:0] {K_NOP, K_R, K_RSH, K_ROT, K_I, K_ILL} kind_e;
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SPEC2 = 6'b011100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_CL1 = 6'b010001;
  localparam logic [5:0] F_CLZ = 6'b100000;
  localparam logic [5:0] F_MUL = 6'b000010;
  localparam logic [5:0] F_ROT = 6'b000110;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational mnemonic + fields (mnem, rs, rt, rd, shamt, imm) -> legal flag and 32-bit MIPS word
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic        legal,
  output logic [31:0] word
);
  logic [5:0] op;
  logic [5:0] func;
  kind_e      kind;
  always_comb begin
    op = OP_RTYPE;
    func = F_SLL;
    kind = K_R;
    case (mnem)
      M_NOP:  kind = K_NOP;
      M_ADD:  func = F_ADD;
      M_SUB:  func = F_SUB;
      M_AND:  func = F_AND;
      M_OR:   func = F_OR;
      M_SLT:  func = F_SLT;
      M_SLL:  kind = K_RSH;
      M_SRL:  begin func = F_SRL; kind = K_RSH; end
      M_CL1:  begin op = OP_SPEC2; func = F_CL1; end
      M_CLZ:  begin op = OP_SPEC2; func = F_CLZ; end
      M_MUL:  begin op = OP_SPEC2; func = F_MUL; end
      M_ROT:  begin op = OP_SPEC2; func = F_ROT; kind = K_ROT; end
      M_ADDI: begin op = OP_ADDI; kind = K_I; end
      M_ORI:  begin op = OP_ORI; kind = K_I; end
      M_LW:   begin op = OP_LW; kind = K_I; end
      M_SW:   begin op = OP_SW; kind = K_I; end
      M_BNE:  begin op = OP_BNE; kind = K_I; end
      default: kind = K_ILL;
    endcase
  end
  assign legal = kind != K_ILL;
  // shifts drop rs; only shifts and ROT carry shamt
  assign word = (kind == K_NOP || kind == K_ILL) ? 32'h0 :
                kind == K_I ? {op, rs, rt, imm} :
                {op, kind == K_RSH ? 5'd0 : rs, rt, rd, kind == K_R ? 5'd0 : shamt, func};
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: session FSM taking one symbolic instruction per handshake and writing its encoding to sequential imem words
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic              done
);
  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic              legal;
  logic [31:0]       word;
  logic              acc;
  instr_pack u_pack (
    .mnem  (mnem),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .shamt (shamt),
    .imm   (imm),
    .legal (legal),
    .word  (word)
  );
  assign in_ready = state == RUN && !start;
  assign acc = in_valid && in_ready;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      ptr <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      word_count <= '0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      mem_we <= acc && legal;
      done <= stop && !start && state != IDLE;
      if (start) begin
        state <= RUN;
        ptr <= '0;
        word_count <= '0;
        err <= 1'b0;
      end else begin
        if (acc && legal) begin
          mem_addr <= ptr;
          mem_wdata <= word;
          ptr <= ptr + ADDR_W'(1);
          word_count <= word_count + (ADDR_W + 1)'(1);
        end
        if (acc && !legal) err <= 1'b1;
        if (stop && state != IDLE) state <= IDLE;
        else if (acc && legal && &ptr) state <= FULL;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder with a 4-word instruction memory
module tb_instr_encoder;
  localparam int AW = 2;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   w;
    logic [AW:0]   c;
  } exp_t;
  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          in_valid = 1'b0;
  logic [4:0]    mnem = '0;
  logic [4:0]    rs = '0;
  logic [4:0]    rt = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    shamt = '0;
  logic [15:0]   imm = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic          err;
  logic          done;
  exp_t          q[$];
  logic [AW-1:0] ptr = '0;
  logic [AW:0]   wc = '0;
  logic [AW-1:0] last_a = '0;
  logic [31:0]   last_w = '0;
  int            checks = 0;
  int            errors = 0;
  instr_encoder #(.ADDR_W(AW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mnem       (mnem),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .imm        (imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .err        (err),
    .done       (done)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("we", 64'(mem_we), 64'(1));
      chk("addr", 64'(mem_addr), 64'(e.a));
      chk("wdata", 64'(mem_wdata), 64'(e.w));
      chk("count", 64'(word_count), 64'(e.c));
      last_a = e.a;
      last_w = e.w;
    end else begin
      chk("we_low", 64'(mem_we), 64'(0));
      chk("addr_hold", 64'(mem_addr), 64'(last_a));
      chk("wdata_hold", 64'(mem_wdata), 64'(last_w));
      chk("count_hold", 64'(word_count), 64'(wc));
    end
  endtask
  task automatic do_start();
    start = 1'b1;
    in_valid = 1'b1;
    mnem = 5'd1;
    #1;
    chk("ready_start", 64'(in_ready), 64'(0));
    ptr = '0;
    wc = '0;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ready_run", 64'(in_ready), 64'(1));
    chk("err_clr", 64'(err), 64'(0));
  endtask
  task automatic send(input logic [4:0] m, a, b, d, s, input logic [15:0] im,
                      input logic lg, input logic [31:0] w, input logic st);
    exp_t e;
    mnem = m; rs = a; rt = b; rd = d; shamt = s; imm = im;
    in_valid = 1'b1;
    stop = st;
    #1;
    chk("ready_send", 64'(in_ready), 64'(1));
    if (lg) begin
      e.a = ptr;
      e.w = w;
      e.c = wc + 1'b1;
      q.push_back(e);
      ptr = ptr + 1'b1;
      wc = wc + 1'b1;
    end
    tick();
    in_valid = 1'b0;
    stop = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("done_pulse", 64'(done), 64'(1));
    tick();
    chk("done_clear", 64'(done), 64'(0));
    chk("ready_idle", 64'(in_ready), 64'(0));
  endtask
  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_count", 64'(word_count), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    Rst_n = 1'b1;
    tick();
    chk("idle_ready", 64'(in_ready), 64'(0));
    do_start();
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 1'b1, 32'h0022_1820, 1'b0);
    do_stop();
    do_start();
    send(5'd14, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 1'b1, 32'h8C85_0008, 1'b0);
    send(5'd6, 5'd9, 5'd2, 5'd6, 5'd4, 16'h0, 1'b1, 32'h0002_3100, 1'b0);
    send(5'd16, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 1'b1, 32'h1422_FFFE, 1'b0);
    send(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 1'b0, 32'h0, 1'b0);
    chk("err_set", 64'(err), 64'(1));
    send(5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 1'b1, 32'h2022_0005, 1'b0);
    chk("full_ready", 64'(in_ready), 64'(0));
    chk("err_sticky", 64'(err), 64'(1));
    do_stop();
    do_start();
    for (int i = 0; i < 4; i++) send(5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1234, 1'b1, 32'h0, 1'b0);
    chk("nop_full_ready", 64'(in_ready), 64'(0));
    chk("nop_full_count", 64'(word_count), 64'(4));
    in_valid = 1'b1;
    mnem = 5'd1;
    tick();
    in_valid = 1'b0;
    do_stop();
    do_start();
    send(5'd13, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 1'b1, 32'h3443_00FF, 1'b0);
    send(5'd10, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 1'b1, 32'h7022_1802, 1'b0);
    send(5'd11, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 1'b1, 32'h7022_1906, 1'b0);
    send(5'd9, 5'd3, 5'd0, 5'd7, 5'd0, 16'h0, 1'b1, 32'h7060_3820, 1'b1);
    chk("stop_done", 64'(done), 64'(1));
    tick();
    chk("stop_idle", 64'(in_ready), 64'(0));
    do_start();
    send(5'd7, 5'd1, 5'd2, 5'd6, 5'd4, 16'h0, 1'b1, 32'h0002_3102, 1'b0);
    send(5'd15, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0010, 1'b1, 32'hAC85_0010, 1'b0);
    mnem = 5'd8; rs = 5'd1; rt = 5'd0; rd = 5'd2; shamt = 5'd3;
    in_valid = 1'b1;
    #1;
    chk("ready_pre_rst", 64'(in_ready), 64'(1));
    #1;
    Rst_n = 1'b0;
    q.delete();
    last_a = '0;
    last_w = '0;
    wc = '0;
    tick();
    in_valid = 1'b0;
    chk("mrst_ready", 64'(in_ready), 64'(0));
    chk("mrst_err", 64'(err), 64'(0));
    chk("mrst_done", 64'(done), 64'(0));
    Rst_n = 1'b1;
    tick();
    chk("drain", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
